// File: rtl/fetch_queue_ctrl.sv
// Instruction fetch queue: buffers 2-wide fetch pairs in a circular queue and
// presents the two oldest entries to decode, which may take 0, 1 or 2 of them
// per cycle. A branch redirect (flush) empties the queue in one edge.
module fetch_queue_ctrl #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       fetch_valid,
    input  logic [W-1:0]               in_inst1,
    input  logic [W-1:0]               in_inst2,
    input  logic [W-1:0]               in_pc1,
    input  logic [W-1:0]               in_pc2,
    output logic                       stall,
    input  logic [1:0]                 dec_ready,
    output logic                       out_valid1,
    output logic                       out_valid2,
    output logic [W-1:0]               out_inst1,
    output logic [W-1:0]               out_inst2,
    output logic [W-1:0]               out_pc1,
    output logic [W-1:0]               out_pc2,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] TWO_C   = CW'(2);

    // Storage carries no reset; only pointers and occupancy are controlled.
    logic [W-1:0]  inst_mem_q [DEPTH];
    logic [W-1:0]  pc_mem_q   [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [PW-1:0] head_nxt;
    logic [PW-1:0] tail_nxt;
    logic          push;
    logic [1:0]    dec_eff;
    logic [1:0]    pop;

    // Second slot of each pair wraps naturally through pointer overflow.
    assign head_nxt = head_q + PW'(1);
    assign tail_nxt = tail_q + PW'(1);

    // Back-pressure is conservative: based on registered occupancy only, so a
    // same-cycle dequeue never unstalls fetch and dec_ready has no path here.
    assign stall = (DEPTH_C - count_q) < TWO_C;
    assign push  = fetch_valid & ~stall;

    // Decode acceptance of 3 behaves as 2, then clamped to what is queued.
    always_comb begin
        dec_eff = (dec_ready == 2'd3) ? 2'd2 : dec_ready;
        pop     = 2'd0;
        if (count_q >= TWO_C) begin
            pop = dec_eff;
        end else if (count_q == CW'(1)) begin
            pop = (dec_eff != 2'd0) ? 2'd1 : 2'd0;
        end
    end

    // Next-state for pointers and occupancy; flush discards push and pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PW'(pop);
            tail_d  = push ? (tail_q + PW'(2)) : tail_q;
            count_d = count_q + (push ? TWO_C : '0) - CW'(pop);
        end
    end

    // Control state register with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Pair write into storage; gated so flushed or reset cycles leave it alone.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            inst_mem_q[tail_q]   <= in_inst1;
            pc_mem_q[tail_q]     <= in_pc1;
            inst_mem_q[tail_nxt] <= in_inst2;
            pc_mem_q[tail_nxt]   <= in_pc2;
        end
    end

    assign out_valid1 = (count_q >= CW'(1));
    assign out_valid2 = (count_q >= TWO_C);

    // Zero-latency read of the two oldest entries, zeroed when not valid.
    assign out_inst1 = out_valid1 ? inst_mem_q[head_q]   : '0;
    assign out_pc1   = out_valid1 ? pc_mem_q[head_q]     : '0;
    assign out_inst2 = out_valid2 ? inst_mem_q[head_nxt] : '0;
    assign out_pc2   = out_valid2 ? pc_mem_q[head_nxt]   : '0;

    assign count = count_q;

endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// Directed bench for fetch_queue_ctrl (DEPTH=8, W=16).
module tb_fetch_queue_ctrl;

    localparam int DEPTH = 8;
    localparam int W     = 16;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         fetch_valid;
    logic [W-1:0] in_inst1, in_inst2, in_pc1, in_pc2;
    logic         stall;
    logic [1:0]   dec_ready;
    logic         out_valid1, out_valid2;
    logic [W-1:0] out_inst1, out_inst2, out_pc1, out_pc2;
    logic [3:0]   count;

    int checks;
    int failures;

    fetch_queue_ctrl #(.DEPTH(DEPTH), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .fetch_valid(fetch_valid),
        .in_inst1   (in_inst1),
        .in_inst2   (in_inst2),
        .in_pc1     (in_pc1),
        .in_pc2     (in_pc2),
        .stall      (stall),
        .dec_ready  (dec_ready),
        .out_valid1 (out_valid1),
        .out_valid2 (out_valid2),
        .out_inst1  (out_inst1),
        .out_inst2  (out_inst2),
        .out_pc1    (out_pc1),
        .out_pc2    (out_pc2),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic fv, input logic [W-1:0] p1, input logic [W-1:0] p2,
                          input logic [1:0] dr);
        fetch_valid = fv;
        in_pc1      = p1;
        in_pc2      = p2;
        in_inst1    = 16'hA001 + p1;
        in_inst2    = 16'hA001 + p2;
        dec_ready   = dr;
    endtask

    task automatic chk_state(input string tag, input int cnt, input logic st,
                             input logic v1, input logic v2,
                             input logic [W-1:0] p1, input logic [W-1:0] p2);
        chk({tag, "_count"}, 32'(count), 32'(cnt));
        chk({tag, "_stall"}, 32'(stall), 32'(st));
        chk({tag, "_v1"},    32'(out_valid1), 32'(v1));
        chk({tag, "_v2"},    32'(out_valid2), 32'(v2));
        chk({tag, "_pc1"},   32'(out_pc1), 32'(p1));
        chk({tag, "_pc2"},   32'(out_pc2), 32'(p2));
        chk({tag, "_i1"},    32'(out_inst1), v1 ? 32'(16'hA001 + p1) : 32'd0);
        chk({tag, "_i2"},    32'(out_inst2), v2 ? 32'(16'hA001 + p2) : 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        flush    = 1'b0;
        set_in(1'b0, '0, '0, 2'd0);
        tick();
        tick();
        rst = 1'b0;
        chk_state("reset", 0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);

        // 1: first pair
        set_in(1'b1, 16'd0, 16'd1, 2'd0);
        tick();
        chk_state("t1", 2, 1'b0, 1'b1, 1'b1, 16'd0, 16'd1);
        chk("t1_inst1_A001", 32'(out_inst1), 32'h0000A001);

        // 2: fill to full
        set_in(1'b1, 16'd2, 16'd3, 2'd0);
        tick();
        chk_state("t2a", 4, 1'b0, 1'b1, 1'b1, 16'd0, 16'd1);
        set_in(1'b1, 16'd4, 16'd5, 2'd0);
        tick();
        chk_state("t2b", 6, 1'b0, 1'b1, 1'b1, 16'd0, 16'd1);
        set_in(1'b1, 16'd6, 16'd7, 2'd0);
        tick();
        chk_state("t2c", 8, 1'b1, 1'b1, 1'b1, 16'd0, 16'd1);
        set_in(1'b1, 16'd8, 16'd9, 2'd0);
        tick();
        chk_state("t2_full_ignored", 8, 1'b1, 1'b1, 1'b1, 16'd0, 16'd1);

        // Drain with mixed acceptance; count 7 still stalls
        set_in(1'b0, '0, '0, 2'd1);
        tick();
        chk_state("dr1", 7, 1'b1, 1'b1, 1'b1, 16'd1, 16'd2);
        set_in(1'b1, 16'd8, 16'd9, 2'd3);
        tick();
        chk_state("dr_stall_push_dropped", 5, 1'b0, 1'b1, 1'b1, 16'd3, 16'd4);
        set_in(1'b0, '0, '0, 2'd2);
        tick();
        chk_state("dr3", 3, 1'b0, 1'b1, 1'b1, 16'd5, 16'd6);
        tick();
        chk_state("dr4", 1, 1'b0, 1'b1, 1'b0, 16'd7, 16'd0);
        tick();
        chk_state("dr5_clamp", 0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        tick();
        chk_state("dr6_empty", 0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);

        // 3: odd head alignment
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_in(1'b1, 16'd3, 16'd4, 2'd0);
        tick();
        set_in(1'b1, 16'd5, 16'd6, 2'd0);
        tick();
        chk_state("t3_fill", 4, 1'b0, 1'b1, 1'b1, 16'd3, 16'd4);
        set_in(1'b0, '0, '0, 2'd1);
        tick();
        chk_state("t3_c3", 3, 1'b0, 1'b1, 1'b1, 16'd4, 16'd5);
        tick();
        chk_state("t3_c2", 2, 1'b0, 1'b1, 1'b1, 16'd5, 16'd6);
        set_in(1'b0, '0, '0, 2'd3);
        tick();
        chk_state("t3_empty", 0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);

        // 4: steady state across wrap
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_in(1'b1, 16'd0, 16'd1, 2'd2);
        tick();
        chk_state("t4_k0", 2, 1'b0, 1'b1, 1'b1, 16'd0, 16'd1);
        for (int k = 1; k < 10; k++) begin
            set_in(1'b1, 16'(2 * k), 16'(2 * k + 1), 2'd2);
            tick();
            chk("t4_count", 32'(count), 32'd2);
            chk("t4_pc1", 32'(out_pc1), 32'(2 * k));
            chk("t4_pc2", 32'(out_pc2), 32'(2 * k + 1));
        end
        set_in(1'b0, '0, '0, 2'd2);
        tick();
        chk_state("t4_drain", 0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);

        // 5: flush beats simultaneous push/pop
        set_in(1'b1, 16'h10, 16'h11, 2'd0);
        tick();
        set_in(1'b1, 16'h12, 16'h13, 2'd0);
        tick();
        set_in(1'b1, 16'h14, 16'h15, 2'd0);
        tick();
        chk_state("t5_c6", 6, 1'b0, 1'b1, 1'b1, 16'h10, 16'h11);
        set_in(1'b1, 16'h16, 16'h17, 2'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_state("t5_flushed", 0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        set_in(1'b1, 16'h40, 16'h41, 2'd0);
        tick();
        chk_state("t5_redirect", 2, 1'b0, 1'b1, 1'b1, 16'h40, 16'h41);

        // 6: reset mid-operation
        set_in(1'b1, 16'h50, 16'h51, 2'd0);
        tick();
        set_in(1'b1, 16'h52, 16'h53, 2'd1);
        tick();
        chk_state("t6_c5", 5, 1'b0, 1'b1, 1'b1, 16'h41, 16'h50);
        set_in(1'b1, 16'h54, 16'h55, 2'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_state("t6_reset", 0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        set_in(1'b1, 16'h60, 16'h61, 2'd0);
        tick();
        chk_state("t6_after", 2, 1'b0, 1'b1, 1'b1, 16'h60, 16'h61);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
